// File: rtl/tlul_host_req_arb.sv
// Round-robin arbiter sharing one TL-UL host adapter port between NumHosts requesters.
// An in-order ID FIFO remembers which host issued each accepted request so responses route back.
module tlul_host_req_arb #(
  parameter int NumHosts = 2,
  parameter int MaxReqs  = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int DBW      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumHosts-1:0]          host_req_i,
  output logic [NumHosts-1:0]          host_gnt_o,
  input  logic [NumHosts*AW-1:0]       host_addr_i,
  input  logic [NumHosts-1:0]          host_we_i,
  input  logic [NumHosts*DW-1:0]       host_wdata_i,
  input  logic [NumHosts*DBW-1:0]      host_be_i,
  output logic [NumHosts-1:0]          host_valid_o,
  output logic [DW-1:0]                host_rdata_o,
  output logic [NumHosts-1:0]          host_err_o,
  output logic                         dn_req_o,
  input  logic                         dn_gnt_i,
  output logic [AW-1:0]                dn_addr_o,
  output logic                         dn_we_o,
  output logic [DW-1:0]                dn_wdata_o,
  output logic [DBW-1:0]               dn_be_o,
  input  logic                         dn_valid_i,
  input  logic [DW-1:0]                dn_rdata_i,
  input  logic                         dn_err_i,
  output logic [$clog2(MaxReqs+1)-1:0] outstanding_o,
  output logic                         rsp_unexp_o
);

  localparam int IW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int PW = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;
  localparam int CW = $clog2(MaxReqs + 1);

  typedef logic [IW-1:0] id_t;

  id_t           ptr_q, lock_idx_q, sel, head;
  logic          lock_q;
  id_t           fifo_q [MaxReqs];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          rsp_unexp_q;
  logic          space, fifo_empty, push, pop, found;
  int            cand;

  // Locked host wins outright; otherwise scan from ptr_q with wrap.
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    cand  = 0;
    if (lock_q) begin
      sel = lock_idx_q;
    end else begin
      for (int i = 0; i < NumHosts; i++) begin
        cand = int'(ptr_q) + i;
        if (cand >= NumHosts) cand = cand - NumHosts;
        if (!found && host_req_i[cand]) begin
          sel   = id_t'(cand);
          found = 1'b1;
        end
      end
    end
  end

  // Space uses the registered count so a same-cycle pop never enables an issue.
  assign space      = (count_q < CW'(MaxReqs));
  assign fifo_empty = (count_q == '0);

  assign dn_req_o   = rst_ni & host_req_i[sel] & space;
  assign dn_addr_o  = host_addr_i[int'(sel)*AW +: AW];
  assign dn_we_o    = host_we_i[sel];
  assign dn_wdata_o = host_wdata_i[int'(sel)*DW +: DW];
  assign dn_be_o    = host_be_i[int'(sel)*DBW +: DBW];

  assign push = dn_req_o & dn_gnt_i;

  // Empty FIFO with a same-cycle push: the response belongs to the host being granted.
  assign head = fifo_empty ? sel : fifo_q[rd_ptr_q];
  assign pop  = rst_ni & dn_valid_i & (~fifo_empty | push);

  always_comb begin
    host_gnt_o        = '0;
    host_gnt_o[sel]   = push;
    host_valid_o      = '0;
    host_valid_o[head] = pop;
    host_err_o        = '0;
    host_err_o[head]  = pop & dn_err_i;
  end

  assign host_rdata_o  = dn_rdata_i;
  assign outstanding_o = count_q;
  assign rsp_unexp_o   = rsp_unexp_q;

  function automatic id_t next_id(id_t v);
    return (v == id_t'(NumHosts - 1)) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] v);
    return (v == PW'(MaxReqs - 1)) ? '0 : v + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_unexp_q <= 1'b0;
    end else begin
      // A host that stalls on !gnt keeps the port; dropping req releases it.
      lock_q <= dn_req_o & ~dn_gnt_i;
      if (dn_req_o & ~dn_gnt_i) lock_idx_q <= sel;
      if (push) begin
        ptr_q    <= next_id(sel);
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (dn_valid_i & ~pop) rsp_unexp_q <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q and the pointers.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= sel;
  end

endmodule

// File: tb/tb_tlul_host_req_arb.sv
// Directed bench for tlul_host_req_arb: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_tlul_host_req_arb;

  localparam int NH  = 2;
  localparam int MR  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DBW = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NH-1:0]     host_req_i;
  logic [NH-1:0]     host_gnt_o;
  logic [NH*AW-1:0]  host_addr_i;
  logic [NH-1:0]     host_we_i;
  logic [NH*DW-1:0]  host_wdata_i;
  logic [NH*DBW-1:0] host_be_i;
  logic [NH-1:0]     host_valid_o;
  logic [DW-1:0]     host_rdata_o;
  logic [NH-1:0]     host_err_o;
  logic              dn_req_o;
  logic              dn_gnt_i;
  logic [AW-1:0]     dn_addr_o;
  logic              dn_we_o;
  logic [DW-1:0]     dn_wdata_o;
  logic [DBW-1:0]    dn_be_o;
  logic              dn_valid_i;
  logic [DW-1:0]     dn_rdata_i;
  logic              dn_err_i;
  logic [1:0]        outstanding_o;
  logic              rsp_unexp_o;

  tlul_host_req_arb #(.NumHosts(NH), .MaxReqs(MR), .AW(AW), .DW(DW), .DBW(DBW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_wdata_i(host_wdata_i), .host_be_i(host_be_i),
    .host_valid_o(host_valid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dn_req_o(dn_req_o), .dn_gnt_i(dn_gnt_i), .dn_addr_o(dn_addr_o), .dn_we_o(dn_we_o),
    .dn_wdata_o(dn_wdata_o), .dn_be_o(dn_be_o), .dn_valid_i(dn_valid_i),
    .dn_rdata_i(dn_rdata_i), .dn_err_i(dn_err_i),
    .outstanding_o(outstanding_o), .rsp_unexp_o(rsp_unexp_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int host; logic [31:0] addr; logic we; } gnt_exp_t;
  typedef struct { int host; logic err; logic [31:0] data; } rsp_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];
  gnt_exp_t g;
  rsp_exp_t r;
  int errors = 0;
  int checks = 0;

  // Host h drives address 0x1000*(h+1); host 1 writes, host 0 reads.
  function automatic logic [31:0] addr_of(int h);
    return 32'h1000 * (h + 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear();
    host_req_i = '0;
    dn_gnt_i   = 1'b0;
    dn_valid_i = 1'b0;
    dn_err_i   = 1'b0;
    dn_rdata_i = '0;
  endtask

  task automatic exp_gnt(input int h);
    gq.push_back('{h, addr_of(h), (h == 1)});
  endtask

  task automatic exp_rsp(input int h, input logic e, input logic [31:0] d);
    rq.push_back('{h, e, d});
  endtask

  // Reset is held with every input active to show outputs are forced low.
  task automatic do_reset();
    rst_ni     = 1'b0;
    host_req_i = '1;
    dn_gnt_i   = 1'b1;
    dn_valid_i = 1'b1;
    step();
    settle();
    chk("rst_dn_req", dn_req_o, 0);
    chk("rst_gnt", host_gnt_o, 0);
    chk("rst_valid", host_valid_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_unexp", rsp_unexp_o, 0);
    clear();
    step();
    rst_ni = 1'b1;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (gq.size() != 0) begin
        g = gq.pop_front();
        chk("gnt_host", host_gnt_o, 64'd1 << g.host);
        chk("gnt_addr", dn_addr_o, g.addr);
        chk("gnt_we", dn_we_o, g.we);
      end else if (host_gnt_o != '0) begin
        chk("gnt_unexpected", host_gnt_o, 0);
      end
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("rsp_valid", host_valid_o, 64'd1 << r.host);
        chk("rsp_err", host_err_o, r.err ? (64'd1 << r.host) : 64'd0);
        chk("rsp_data", host_rdata_o, r.data);
      end else if (host_valid_o != '0) begin
        chk("rsp_unexpected", host_valid_o, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni       = 1'b0;
    host_addr_i  = {32'h2000, 32'h1000};
    host_we_i    = 2'b10;
    host_wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
    host_be_i    = {4'hF, 4'h3};
    clear();

    // Continuous requests, responses one cycle behind: grants alternate 0,1,0,1.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      host_req_i = (i < 4) ? 2'b11 : 2'b00;
      dn_gnt_i   = 1'b1;
      dn_valid_i = (i > 0);
      dn_rdata_i = 32'hA000 + i;
      if (i < 4) exp_gnt(i % 2);
      if (i > 0) exp_rsp((i - 1) % 2, 1'b0, 32'hA000 + i);
      step();
    end
    clear();
    settle();
    chk("rr_outstanding", outstanding_o, 0);

    // Stalled host1 keeps the port even when host0 (favoured by ptr) joins.
    do_reset();
    host_req_i = 2'b10;
    settle();
    chk("lock_c0_addr", dn_addr_o, 32'h2000);
    chk("lock_c0_req", dn_req_o, 1);
    step();
    host_req_i = 2'b11;
    settle();
    chk("lock_c1_addr", dn_addr_o, 32'h2000);
    step();
    settle();
    chk("lock_c2_addr", dn_addr_o, 32'h2000);
    step();
    dn_gnt_i = 1'b1;
    exp_gnt(1);
    step();
    host_req_i = 2'b01;
    exp_gnt(0);
    step();
    clear();
    dn_valid_i = 1'b1;
    dn_rdata_i = 32'hB1;
    exp_rsp(1, 1'b0, 32'hB1);
    step();
    dn_rdata_i = 32'hB2;
    exp_rsp(0, 1'b0, 32'hB2);
    step();
    clear();
    settle();
    chk("lock_outstanding", outstanding_o, 0);

    // FIFO full stalls issue; a pop frees space only from the next cycle.
    do_reset();
    host_req_i = 2'b11;
    dn_gnt_i   = 1'b1;
    exp_gnt(0);
    step();
    exp_gnt(1);
    step();
    settle();
    chk("full_req", dn_req_o, 0);
    chk("full_outstanding", outstanding_o, 2);
    step();
    dn_valid_i = 1'b1;
    dn_rdata_i = 32'hC0;
    exp_rsp(0, 1'b0, 32'hC0);
    settle();
    chk("pop_no_free", dn_req_o, 0);
    step();
    dn_valid_i = 1'b0;
    exp_gnt(0);
    settle();
    chk("resume_outstanding", outstanding_o, 1);
    step();
    host_req_i = 2'b00;
    dn_valid_i = 1'b1;
    dn_rdata_i = 32'hC1;
    exp_rsp(1, 1'b0, 32'hC1);
    step();
    dn_rdata_i = 32'hC2;
    exp_rsp(0, 1'b0, 32'hC2);
    step();
    clear();
    settle();
    chk("full_drain", outstanding_o, 0);

    // Error routed to the host whose request it answers.
    do_reset();
    host_req_i = 2'b01;
    dn_gnt_i   = 1'b1;
    exp_gnt(0);
    step();
    host_req_i = 2'b10;
    exp_gnt(1);
    step();
    clear();
    dn_valid_i = 1'b1;
    dn_err_i   = 1'b1;
    dn_rdata_i = 32'hD0;
    exp_rsp(0, 1'b1, 32'hD0);
    step();
    dn_err_i   = 1'b0;
    dn_rdata_i = 32'hD1;
    exp_rsp(1, 1'b0, 32'hD1);
    step();
    clear();

    // Same-cycle grant and response on empty FIFO, then a stray response.
    do_reset();
    host_req_i = 2'b01;
    dn_gnt_i   = 1'b1;
    dn_valid_i = 1'b1;
    dn_rdata_i = 32'hE0;
    exp_gnt(0);
    exp_rsp(0, 1'b0, 32'hE0);
    step();
    clear();
    settle();
    chk("bypass_outstanding", outstanding_o, 0);
    chk("bypass_no_unexp", rsp_unexp_o, 0);
    dn_valid_i = 1'b1;
    dn_rdata_i = 32'hE1;
    step();
    clear();
    settle();
    chk("unexp_set", rsp_unexp_o, 1);
    step();
    step();
    settle();
    chk("unexp_sticky", rsp_unexp_o, 1);

    // Reset with two outstanding leaving ptr at 1: IDs lost, ptr back to 0.
    do_reset();
    host_req_i = 2'b10;
    dn_gnt_i   = 1'b1;
    exp_gnt(1);
    step();
    host_req_i = 2'b01;
    exp_gnt(0);
    step();
    clear();
    settle();
    chk("pre_rst_outstanding", outstanding_o, 2);
    do_reset();
    host_req_i = 2'b11;
    dn_gnt_i   = 1'b1;
    exp_gnt(0);
    step();
    host_req_i = 2'b10;
    exp_gnt(1);
    step();
    clear();
    dn_valid_i = 1'b1;
    dn_rdata_i = 32'hF0;
    exp_rsp(0, 1'b0, 32'hF0);
    step();
    dn_rdata_i = 32'hF1;
    exp_rsp(1, 1'b0, 32'hF1);
    step();
    dn_rdata_i = 32'hF2;
    step();
    clear();
    settle();
    chk("late_unexp", rsp_unexp_o, 1);
    chk("late_outstanding", outstanding_o, 0);

    step();
    chk("gnt_queue_drained", gq.size(), 0);
    chk("rsp_queue_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
